// File: rtl/shr_line_engine.sv
// Super Hi-Res scanline engine: per-line SCB/palette fetch, pixel streaming and 320/640/fill render.
// Define SHR_SCANLINE_IRQ_EN to build the latched SCB[6] scanline interrupt.
//
// state | meaning
// IDLE  | no fetch in flight; waits for FETCH_H on a line preceding an active line
// SCB   | SCB address issued, capturing the SCB byte
// PAL   | issuing 32 palette byte addresses and capturing them one tick later
// WAIT  | palette loaded, waiting for H_LEFT-1 to issue the first pixel byte
// PIX   | streaming 160 pixel bytes, one every 4 ticks
module shr_line_engine #(
    parameter int          H_LEFT   = 32,
    parameter int          H_TOTAL  = 912,
    parameter int          V_TOP    = 16,
    parameter int          LINES    = 200,
    parameter int          FETCH_H  = 860,
    parameter logic [22:0] PIX_BASE = 23'h12000,
    parameter logic [22:0] SCB_BASE = 23'h19D00,
    parameter logic [22:0] PAL_BASE = 23'h19E00,
    parameter int          OUT_W    = 8
) (
    input  logic             clk_vid,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [9:0]       H,
    input  logic [8:0]       V,
    input  logic             enable,
    input  logic [11:0]      border_rgb,
    output logic [22:0]      mem_addr,
    input  logic [7:0]       mem_data,
    input  logic             irq_clr,
    output logic             scanline_irq,
    output logic             vbl,
    output logic [OUT_W-1:0] R,
    output logic [OUT_W-1:0] G,
    output logic [OUT_W-1:0] B
);

    localparam logic [9:0] H_FETCH   = 10'(FETCH_H);
    localparam logic [9:0] H_LEFT_V  = 10'(H_LEFT);
    localparam logic [9:0] H_ISSUE0  = 10'(H_LEFT - 1);
    localparam logic [9:0] H_WIN0    = 10'(H_LEFT + 1);
    localparam logic [9:0] H_WIN_END = 10'(H_LEFT + 641);
    localparam logic [9:0] V_FIRST   = 10'(V_TOP);
    localparam logic [9:0] V_END     = 10'(V_TOP + LINES);
    localparam logic [8:0] V_VBL     = 9'(V_TOP + LINES);

    typedef enum logic [2:0] {S_IDLE, S_SCB, S_PAL, S_WAIT, S_PIX} state_t;

    state_t      state_q, state_d;
    logic [7:0]  scb_q;
    logic [7:0]  pix_byte;
    logic [3:0]  last_pixel;
    logic        line_en;
    logic [5:0]  pal_left;
    logic [7:0]  pix_left;
    logic [11:0] pal_ram [16];

    logic [9:0]  v_next;
    logic        next_active, v_active, in_win, at_fetch;
    logic [8:0]  r_next, r_cur;
    logic [1:0]  ph, sub;
    logic [4:0]  k_cap;
    logic [3:0]  nib, idx;
    logic [11:0] colour;

    function automatic logic [OUT_W-1:0] expand(input logic [3:0] n);
        logic [11:0] rep;
        rep = {n, n, n};
        return rep[11 -: OUT_W];
    endfunction

    assign v_next      = {1'b0, V} + 10'd1;
    assign next_active = (v_next >= V_FIRST) && (v_next < V_END);
    assign v_active    = ({1'b0, V} >= V_FIRST) && ({1'b0, V} < V_END);
    assign r_next      = 9'(v_next - V_FIRST);
    assign r_cur       = 9'({1'b0, V} - V_FIRST);
    assign at_fetch    = (H == H_FETCH);
    assign ph          = 2'(H - H_LEFT_V);
    assign sub         = 2'(H - H_WIN0);
    assign in_win      = line_en && v_active && (H >= H_WIN0) && (H < H_WIN_END);
    assign k_cap       = 5'd31 - pal_left[4:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (at_fetch && enable && next_active) state_d = S_SCB;
            S_SCB:  state_d = S_PAL;
            S_PAL:  if (pal_left == 6'd0) state_d = S_WAIT;
            S_WAIT: if (H == H_ISSUE0) state_d = S_PIX;
            S_PIX:  if (ph == 2'd0 && pix_left == 8'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_vid) begin
        if (reset) state_q <= S_IDLE;
        else if (ce_pix) state_q <= state_d;
    end

    // Pixel index: 640 mode interleaves two palette halves; fill mode reuses the last non-zero index.
    always_comb begin
        nib = sub[1] ? pix_byte[3:0] : pix_byte[7:4];
        idx = nib;
        if (scb_q[7]) begin
            case (sub)
                2'd0:    idx = {2'b10, pix_byte[7:6]};
                2'd1:    idx = {2'b11, pix_byte[5:4]};
                2'd2:    idx = {2'b00, pix_byte[3:2]};
                default: idx = {2'b01, pix_byte[1:0]};
            endcase
        end else if (scb_q[5] && nib == 4'd0) begin
            idx = last_pixel;
        end
        colour = pal_ram[idx];
    end

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) pal_ram[i] <= '0;
        end else if (ce_pix && state_q == S_PAL && pal_left != 6'd32) begin
            if (k_cap[0]) pal_ram[k_cap[4:1]][11:8] <= mem_data[3:0];
            else          pal_ram[k_cap[4:1]][7:0]  <= mem_data;
        end
    end

    // line_en resets high so a line interrupted by reset shows black in the active area, not border.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            mem_addr   <= '0;
            scb_q      <= '0;
            pix_byte   <= '0;
            last_pixel <= '0;
            line_en    <= 1'b1;
            pal_left   <= '0;
            pix_left   <= '0;
            vbl        <= 1'b0;
            R          <= '0;
            G          <= '0;
            B          <= '0;
        end else if (ce_pix) begin
            vbl <= (V == V_VBL) && (H == 10'd0);
            if (at_fetch) line_en <= enable;

            case (state_q)
                S_IDLE: begin
                    pal_left <= 6'd32;
                    if (state_d == S_SCB) mem_addr <= SCB_BASE + 23'(r_next);
                end
                S_SCB: scb_q <= mem_data;
                S_PAL: begin
                    if (pal_left != 6'd0) begin
                        pal_left <= pal_left - 6'd1;
                        if (enable) begin
                            if (pal_left == 6'd32)
                                mem_addr <= PAL_BASE + {14'd0, scb_q[3:0], 5'd0};
                            else
                                mem_addr <= mem_addr + 23'd1;
                        end
                    end
                end
                S_WAIT: begin
                    pix_left <= 8'd159;
                    if (H == H_ISSUE0 && enable)
                        mem_addr <= PIX_BASE + 23'({r_cur, 7'd0}) + 23'({r_cur, 5'd0});
                end
                S_PIX: begin
                    if (ph == 2'd0) begin
                        pix_byte <= mem_data;
                        if (pix_left != 8'd0) pix_left <= pix_left - 8'd1;
                    end
                    if (ph == 2'd3 && enable) mem_addr <= mem_addr + 23'd1;
                end
                default: ;
            endcase

            if (H == H_LEFT_V) last_pixel <= 4'd0;

            if (in_win) begin
                R <= expand(colour[11:8]);
                G <= expand(colour[7:4]);
                B <= expand(colour[3:0]);
                if (!scb_q[7]) last_pixel <= idx;
            end else begin
                R <= expand(border_rgb[11:8]);
                G <= expand(border_rgb[7:4]);
                B <= expand(border_rgb[3:0]);
            end
        end
    end

`ifdef SHR_SCANLINE_IRQ_EN
    always_ff @(posedge clk_vid) begin
        if (reset) scanline_irq <= 1'b0;
        else if (ce_pix) begin
            if (state_q == S_SCB && mem_data[6]) scanline_irq <= 1'b1;
            else if (irq_clr)                     scanline_irq <= 1'b0;
        end
    end
    logic unused_bits;
    assign unused_bits = ^{scb_q[6], scb_q[4]};
`else
    assign scanline_irq = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{scb_q[6], scb_q[4], irq_clr};
`endif

endmodule

// File: tb/tb_shr_line_engine.sv
// Directed bench for shr_line_engine: drives H/V counters and a byte-wide video memory model.
module tb_shr_line_engine;

    localparam int FETCH_H = 860;
    localparam int H_TOTAL = 912;

`ifdef SHR_SCANLINE_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk_vid = 1'b0;
    logic        reset = 1'b1;
    logic        ce_pix = 1'b0;
    logic [9:0]  H = '0;
    logic [8:0]  V = '0;
    logic        enable = 1'b1;
    logic [11:0] border_rgb = 12'h4C7;
    logic [22:0] mem_addr;
    logic [7:0]  mem_data;
    logic        irq_clr = 1'b0;
    logic        scanline_irq;
    logic        vbl;
    logic [7:0]  R, G, B;

    logic [7:0]  vram [131072];
    int          last_h = -1;
    int          last_v = -1;
    int          n_checks = 0;
    int          n_errors = 0;

    shr_line_engine dut (
        .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix), .H(H), .V(V),
        .enable(enable), .border_rgb(border_rgb), .mem_addr(mem_addr),
        .mem_data(mem_data), .irq_clr(irq_clr), .scanline_irq(scanline_irq),
        .vbl(vbl), .R(R), .G(G), .B(B)
    );

    always #5 clk_vid = ~clk_vid;

    assign mem_data = (mem_addr[22:17] == 6'd0) ? vram[mem_addr[16:0]] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (V=%0d H=%0d)", tag, got, exp, last_v, last_h);
        end
    endtask

    task automatic chk_rgb(input string tag, input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        chk({tag, "_r"}, 32'(R), 32'(er));
        chk({tag, "_g"}, 32'(G), 32'(eg));
        chk({tag, "_b"}, 32'(B), 32'(eb));
    endtask

    // One pixel tick: a ce_pix clock, then an idle clock; outputs sampled after both.
    task automatic tick();
        ce_pix = 1'b1;
        @(posedge clk_vid); #1;
        last_h = int'(H);
        last_v = int'(V);
        if (int'(H) == H_TOTAL - 1) begin
            H = '0;
            V = (V == 9'd261) ? 9'd0 : V + 9'd1;
        end else begin
            H = H + 10'd1;
        end
        ce_pix = 1'b0;
        @(posedge clk_vid); #1;
    endtask

    task automatic run_to(input int tv, input int th);
        for (int n = 0; n < 4000; n++) begin
            if (last_v == tv && last_h == th) break;
            tick();
        end
        if (!(last_v == tv && last_h == th))
            chk("run_to", 32'((last_v << 10) | last_h), 32'((tv << 10) | th));
    endtask

    task automatic pal_entry(input int pal, input int ent, input logic [7:0] gb, input logic [7:0] r);
        vram[17'h19E00 + pal * 32 + ent * 2]     = gb;
        vram[17'h19E00 + pal * 32 + ent * 2 + 1] = r;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 131072; i++) vram[i] = 8'h00;
        vram[17'h19D00 + 0] = 8'h01;
        vram[17'h19D00 + 1] = 8'h80;
        vram[17'h19D00 + 2] = 8'h20;
        vram[17'h19D00 + 3] = 8'h20;
        vram[17'h19D00 + 5] = 8'h40;
        vram[17'h19D00 + 6] = 8'h40;
        vram[17'h19D00 + 7] = 8'h01;
        pal_entry(1, 2,  8'h5A, 8'h03);
        pal_entry(1, 15, 8'h21, 8'h0C);
        pal_entry(0, 0,  8'h11, 8'h0F);
        pal_entry(0, 2,  8'h78, 8'h09);
        pal_entry(0, 3,  8'h34, 8'h05);
        pal_entry(0, 5,  8'h67, 8'h08);
        pal_entry(0, 7,  8'hAB, 8'h0E);
        pal_entry(0, 8,  8'h12, 8'h03);
        pal_entry(0, 13, 8'h45, 8'h06);
        vram[17'h12000]       = 8'h2F;
        vram[17'h12000 + 160] = 8'h1B;
        vram[17'h12000 + 320] = 8'h30;
        vram[17'h12000 + 321] = 8'h00;
        vram[17'h12000 + 480] = 8'h05;

        // reset state
        repeat (3) tick();
        chk_rgb("rst0", 8'h00, 8'h00, 8'h00);
        chk("rst0_addr", 32'(mem_addr), 32'h0);
        chk("rst0_irq", 32'(scanline_irq), 32'h0);
        chk("rst0_vbl", 32'(vbl), 32'h0);
        reset = 1'b0;

        // row 0: 320 mode, palette 1
        H = 10'(FETCH_H - 2); V = 9'd15;
        run_to(15, FETCH_H);
        chk("scb_addr", 32'(mem_addr), 32'h19D00);
        run_to(15, FETCH_H + 2);
        chk("pal_addr0", 32'(mem_addr), 32'h19E20);
        tick();
        chk("pal_addr1", 32'(mem_addr), 32'h19E21);
        run_to(16, 31);
        chk("pix_addr_r0", 32'(mem_addr), 32'h12000);
        tick();
        chk_rgb("r0_lborder", 8'h44, 8'hCC, 8'h77);
        tick();
        chk_rgb("r0_px0", 8'h33, 8'h55, 8'hAA);
        tick();
        chk_rgb("r0_px1", 8'h33, 8'h55, 8'hAA);
        tick();
        chk_rgb("r0_px2", 8'hCC, 8'h22, 8'h11);

        // row 1: 640 mode, byte 1B -> indices 8,13,2,7
        run_to(17, 31);
        chk("pix_addr_r1", 32'(mem_addr), 32'h120A0);
        run_to(17, 33);
        chk_rgb("r1_px0", 8'h33, 8'h11, 8'h22);
        tick();
        chk_rgb("r1_px1", 8'h66, 8'h44, 8'h55);
        tick();
        chk_rgb("r1_px2", 8'h99, 8'h77, 8'h88);
        tick();
        chk_rgb("r1_px3", 8'hEE, 8'hAA, 8'hBB);

        // row 2: fill mode, bytes 30 00 -> index 3 throughout
        for (int px = 0; px < 6; px++) begin
            run_to(18, 33 + px);
            chk_rgb("r2_fill", 8'h55, 8'h33, 8'h44);
        end

        // row 3: fill mode, leading index 0 must use entry 0
        run_to(19, 33);
        chk_rgb("r3_px0", 8'hFF, 8'h11, 8'h11);
        run_to(19, 35);
        chk_rgb("r3_px2", 8'h88, 8'h66, 8'h77);

        // scanline interrupt on rows 5 and 6
        run_to(20, FETCH_H);
        chk("irq_pre", 32'(scanline_irq), 32'h0);
        tick();
        chk("irq_set", 32'(scanline_irq), 32'(IRQ_ON));
        run_to(21, 100);
        chk("irq_hold", 32'(scanline_irq), 32'(IRQ_ON));
        run_to(21, 199);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        chk("irq_clr", 32'(scanline_irq), 32'h0);
        run_to(21, FETCH_H);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        chk("irq_set_wins", 32'(scanline_irq), 32'(IRQ_ON));
        run_to(21, 900);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        chk("irq_clr2", 32'(scanline_irq), 32'h0);

        // reset mid palette fetch for row 7
        run_to(22, FETCH_H + 9);
        reset = 1'b1;
        repeat (3) tick();
        chk_rgb("rst1", 8'h00, 8'h00, 8'h00);
        chk("rst1_addr", 32'(mem_addr), 32'h0);
        chk("rst1_irq", 32'(scanline_irq), 32'h0);
        chk("rst1_vbl", 32'(vbl), 32'h0);
        reset = 1'b0;
        run_to(23, 10);
        chk_rgb("rst_border", 8'h44, 8'hCC, 8'h77);
        run_to(23, 83);
        chk_rgb("rst_black", 8'h00, 8'h00, 8'h00);

        // SHR disabled: border everywhere, vbl pulse, address held
        enable = 1'b0;
        border_rgb = 12'hD03;
        H = 10'(FETCH_H - 3); V = 9'd214;
        run_to(214, 911);
        for (int i = 0; i < 1000; i++) begin
            tick();
            chk("vbl", 32'(vbl), 32'(last_v == 216 && last_h == 0));
            if (i % 16 == 0) chk_rgb("dis_border", 8'hDD, 8'h00, 8'h33);
        end
        chk("dis_addr_hold", 32'(mem_addr), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
